fft_mem_sequencer: RTL
======================

// Module: fft_mem_sequencer
// PURPOSE
// - Owns the 4096x32 FFT working RAM: arbitrates AXI host access against the FFT core.
// - Generates in-place radix-2 DIT butterfly read/write-back addresses and twiddle indices per stage.
// - Sits between AXI slave, FFT butterfly datapath and RAM; drives RAM mode select.
// PARAMETERS
// - ADDR_W   12  RAM address width
// - N_LOG2   12  log2(FFT points); N = 2**N_LOG2, N_LOG2 <= ADDR_W, N_LOG2 >= 2
// - BF_LAT   4   cycles from read of operand A to write-back of result A (>= 2)
// PORTS
// - clk        in   1                   clock, rising edge
// - rst_n      in   1                   async active-low reset
// - start      in   1                   FFT start request, sampled in IDLE only
// - axi_req    in   1                   host requests RAM ownership (level)
// - axi_grant  out  1                   host owns RAM
// - mem_mode   out  1                   RAM mode: 1 = AXI port, 0 = FFT port
// - busy       out  1                   FFT in progress (RUN or DRAIN)
// - done       out  1                   1-cycle pulse, FFT complete
// - rd_en      out  1                   datapath operand read strobe
// - rd_adr     out  ADDR_W              operand read address
// - tw_idx     out  N_LOG2-1            twiddle index, valid with rd_en on A reads
// - wr_en      out  1                   result write-back strobe
// - wr_adr     out  ADDR_W              write-back address
// - stage      out  $clog2(N_LOG2)      current stage number
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE; mem_mode=1; axi_grant/busy/done/rd_en/wr_en=0;
//   rd_adr/wr_adr/tw_idx/stage=0; in-flight pipeline cleared. Reset mid-FFT aborts, no done.
// - States: IDLE, AXI, RUN, DRAIN, DONE.
//   IDLE: start=1 -> RUN (start wins over simultaneous axi_req); else axi_req=1 -> AXI.
//   AXI : axi_grant=1, mem_mode=1; stays while axi_req=1; axi_req=0 -> IDLE. start ignored.
//   RUN : mem_mode=0, busy=1; issues reads for current stage; after last read -> DRAIN.
//   DRAIN: no reads; waits for final write-back of stage; then next stage -> RUN,
//          or last stage -> DONE.
//   DONE: done=1 one cycle, mem_mode returns to 1 -> IDLE. axi_req during RUN/DRAIN waits.
// - Addressing, stage s in 0..N_LOG2-1, butterfly k in 0..N/2-1 (k increments every 2 cycles):
//   half = 1<<s; pos = k & (half-1); a = ((k>>s)<<(s+1)) | pos; b = a + half;
//   tw = pos << (N_LOG2-1-s).
// - Read issue: 2 cycles per butterfly, rd_adr=a then rd_adr=b; tw_idx=tw on A cycle.
//   Stage reads take N cycles, back-to-back.
// - Write-back: rd_adr delayed by a BF_LAT-deep shift register; wr_en/wr_adr mirror
//   rd_en/rd_adr exactly BF_LAT cycles later.
// - Timing: start accepted cycle 0, first rd_en cycle 1. Each stage takes N+BF_LAT cycles
//   (N read + BF_LAT drain). Next stage's first read is the cycle after previous stage's last write.
//   done at cycle 1 + N_LOG2*(N+BF_LAT).
// - stage updates on the RUN entry cycle of each stage; counters wrap cleanly to 0 after last stage.
// CONFIGURATION
// - FFT_ABORT_EN defined: adds input port abort (1 bit).
//   abort=1 in RUN stops read issue that cycle; DRAIN completes in-flight writes; -> IDLE without done.
//   abort is ignored in IDLE/AXI/DONE.
// - FFT_ABORT_EN undefined: no abort port; an FFT always runs to completion or reset.
// TESTING (N_LOG2=3, BF_LAT=4, N=8 unless noted)
// - Reset: rst_n=0 mid-RUN -> same cycle mem_mode=1, busy=0, rd_en=wr_en=0; after release IDLE, no done.
// - start at cycle 0 -> stage0 rd_adr 0,1,2,3,4,5,6,7 cycles 1..8, tw_idx=0;
//   wr_adr 0..7 cycles 5..12.
// - Stage 2 -> rd_adr 0,4,1,5,2,6,3,7; tw_idx 0,1,2,3 on A cycles;
//   done single pulse at cycle 37.
// - Arbitration: axi_req held from cycle 3 -> axi_grant=0 through DONE; axi_grant=1 at cycle 39.
//   start and axi_req both 1 in IDLE -> RUN, grant=0.
// - AXI hold: axi_req=1 for 10 cycles, start pulsed at cycle 5 -> start ignored;
//   IDLE one cycle after axi_req drops; busy stays 0.
// - FFT_ABORT_EN: abort at cycle 4 -> last rd_en cycle 3; wr_en cycles 5..7;
//   IDLE at cycle 8; done never asserts.

Source files
------------

// File: rtl/fft_mem_sequencer_if.sv
// ---------------------------------------------------------------------------
// fft_mem_sequencer_if
// Bundles the control, arbitration and address-generation signals of the
// FFT working-RAM sequencer.
//   master : host/test side (drives start, axi_req and optionally abort)
//   slave  : sequencer side (drives grant, RAM mode, status and addresses)
// Signals:
//   start, axi_req, abort (FFT_ABORT_EN only)  -> sequencer
//   axi_grant, mem_mode, busy, done            <- sequencer
//   rd_en, rd_adr, tw_idx                      <- operand read side
//   wr_en, wr_adr                              <- write-back side
//   stage                                      <- current FFT stage
// Optional feature macro: FFT_ABORT_EN adds the abort request.
// ---------------------------------------------------------------------------
interface fft_mem_sequencer_if #(
  parameter int ADDR_W = 12,
  parameter int N_LOG2 = 12
);
  localparam int STG_W = $clog2(N_LOG2);

  logic              start;
  logic              axi_req;
  logic              axi_grant;
  logic              mem_mode;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_adr;
  logic [N_LOG2-2:0] tw_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_adr;
  logic [STG_W-1:0]  stage;
`ifdef FFT_ABORT_EN
  logic              abort;
`endif

  modport master (
    output
`ifdef FFT_ABORT_EN
      abort,
`endif
      start, axi_req,
    input  axi_grant, mem_mode, busy, done, rd_en, rd_adr, tw_idx,
           wr_en, wr_adr, stage
  );

  modport slave (
    input
`ifdef FFT_ABORT_EN
      abort,
`endif
      start, axi_req,
    output axi_grant, mem_mode, busy, done, rd_en, rd_adr, tw_idx,
           wr_en, wr_adr, stage
  );
endinterface

// File: rtl/fft_mem_sequencer.sv
// ---------------------------------------------------------------------------
// fft_mem_sequencer
// Owns the FFT working RAM: arbitrates host (AXI) ownership against the FFT
// core and generates in-place radix-2 DIT butterfly addresses per stage.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fft_mem_sequencer_if.slave (start/axi_req in; grant, RAM mode,
//            busy/done, read/write-back strobes and addresses, twiddle index,
//            stage out)
// Optional feature macro: FFT_ABORT_EN (abort input stops an FFT after its
// in-flight write-backs drain, without signalling done).
// ---------------------------------------------------------------------------
module fft_mem_sequencer #(
  parameter int ADDR_W = 12,
  parameter int N_LOG2 = 12,
  parameter int BF_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  fft_mem_sequencer_if.slave bus
);
  localparam int STG_W = $clog2(N_LOG2);
  localparam int TW_W  = N_LOG2 - 1;

  typedef enum logic [2:0] {S_IDLE, S_AXI, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] rd_cnt_q;      // {butterfly k, A/B phase}
  logic [STG_W-1:0]  stage_q;
  logic              abort_q;
  logic              abort_req;
  logic              issue;
  logic              pipe_pending;
  logic [ADDR_W-1:0] k_ext, half, mask, adr_a, adr_b, rd_adr_c;
  logic [STG_W-1:0]  tw_sh;
  logic [TW_W-1:0]   tw;
  logic              wb_vld_p [BF_LAT];
  logic [ADDR_W-1:0] wb_adr_p [BF_LAT];

`ifdef FFT_ABORT_EN
  assign abort_req = (state_q == S_RUN) && bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // An abort suppresses the read in the very cycle it is seen.
  assign issue = (state_q == S_RUN) && !abort_req;

  // Butterfly k of stage s: A = k with a zero inserted at bit s, B = A + 2^s.
  always_comb begin
    k_ext = ADDR_W'(rd_cnt_q[N_LOG2-1:1]);
    half  = ADDR_W'(1) << stage_q;
    mask  = half - ADDR_W'(1);
    adr_a = ((k_ext & ~mask) << 1) | (k_ext & mask);
    adr_b = adr_a | half;
    tw_sh = STG_W'(N_LOG2 - 1) - stage_q;
    tw    = TW_W'(k_ext & mask) << tw_sh;
  end

  assign rd_adr_c = !issue ? '0 : (rd_cnt_q[0] ? adr_b : adr_a);

  // Write-backs still to come behind the one leaving the pipe this cycle.
  always_comb begin
    pipe_pending = 1'b0;
    for (int i = 0; i < BF_LAT - 1; i++) pipe_pending = pipe_pending | wb_vld_p[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start)        state_d = S_RUN;
        else if (bus.axi_req) state_d = S_AXI;
      end
      S_AXI:   if (!bus.axi_req) state_d = S_IDLE;
      S_RUN:   if (abort_req || (&rd_cnt_q)) state_d = S_DRAIN;
      S_DRAIN: begin
        if (!pipe_pending) begin
          if (abort_q)                           state_d = S_IDLE;
          else if (stage_q == STG_W'(N_LOG2 - 1)) state_d = S_DONE;
          else                                   state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rd_cnt_q <= '0;
      stage_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue)                rd_cnt_q <= rd_cnt_q + 1'b1;
      else if (state_q != S_RUN) rd_cnt_q <= '0;
      if (state_q == S_DRAIN && state_d == S_RUN)       stage_q <= stage_q + 1'b1;
      else if (state_q == S_DRAIN && state_d != S_DRAIN) stage_q <= '0;
      if (abort_req)                                    abort_q <= 1'b1;
      else if (state_q != S_RUN && state_q != S_DRAIN)  abort_q <= 1'b0;
    end
  end

  // ---- write-back delay line: p[0] .. p[BF_LAT-1] ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BF_LAT; i++) begin
        wb_vld_p[i] <= 1'b0;
        wb_adr_p[i] <= '0;
      end
    end else begin
      wb_vld_p[0] <= issue;
      wb_adr_p[0] <= rd_adr_c;
      for (int i = 1; i < BF_LAT; i++) begin
        wb_vld_p[i] <= wb_vld_p[i-1];
        wb_adr_p[i] <= wb_adr_p[i-1];
      end
    end
  end

  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.mem_mode  = !bus.busy;
  assign bus.axi_grant = (state_q == S_AXI);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_adr    = rd_adr_c;
  assign bus.tw_idx    = (issue && !rd_cnt_q[0]) ? tw : '0;
  assign bus.wr_en     = wb_vld_p[BF_LAT-1];
  assign bus.wr_adr    = wb_adr_p[BF_LAT-1];
  assign bus.stage     = stage_q;
endmodule
